// File: rtl/door_pkg.sv
// Shared definitions for the level-exit door: FSM state encoding, sprite
// geometry constants and the frame-RAM address width.
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    DONE
  } door_state_t;

  localparam int DOOR_W_C   = 60;
  localparam int DOOR_H_C   = 80;
  localparam int DOOR_WORDS = DOOR_W_C * DOOR_H_C;
  localparam int ADDR_W     = $clog2(DOOR_WORDS);

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/door_addr_gen.sv
// Sprite hit test and frame-RAM read address generator.
// Maps the current scan position plus camera scroll into world coordinates,
// decides whether the pixel falls inside the sprite box and, if so, forms the
// row-major RAM address for a 60-pixel-wide sprite.
//
// Ports:
//   drawx, drawy  in   current scan position
//   zerox         in   camera scroll (world x of screen column 0)
//   hit           out  pixel lies inside the sprite box
//   row           out  sprite row offset (valid when hit)
//   read_address  out  frame RAM address, 0 when not hit
module door_addr_gen
  import door_pkg::*;
#(
  parameter int SPRITE_X = 2416,
  parameter int SPRITE_Y = 96,
  parameter int SPRITE_W = DOOR_W_C,
  parameter int SPRITE_H = DOOR_H_C
) (
  input  logic [9:0]        drawx,
  input  logic [9:0]        drawy,
  input  logic [11:0]       zerox,
  output logic              hit,
  output logic [6:0]        row,
  output logic [ADDR_W-1:0] read_address
);

  localparam logic [11:0] X_LO = 12'(SPRITE_X);
  localparam logic [11:0] X_HI = 12'(SPRITE_X + SPRITE_W - 1);
  localparam logic [11:0] Y_LO = 12'(SPRITE_Y);
  localparam logic [11:0] Y_HI = 12'(SPRITE_Y + SPRITE_H - 1);

  logic [11:0] nowx;
  logic [11:0] nowy;
  logic [5:0]  col;

  // World x wraps modulo 4096, so a scroll that wraps past the end of the
  // world lands at small x values and can never fall inside the box.
  // Offsets only need their low bits because they are used only when hit.
  // The row*60 product is (row<<6) - (row<<2), which keeps the address path
  // free of a multiplier; it assumes the sprite is exactly 60 pixels wide.
  always_comb begin
    nowx = {2'b00, drawx} + zerox;
    nowy = {2'b00, drawy};
    hit  = (nowx >= X_LO) && (nowx <= X_HI) && (nowy >= Y_LO) && (nowy <= Y_HI);
    col  = nowx[5:0] - X_LO[5:0];
    row  = nowy[6:0] - Y_LO[6:0];
    if (hit) begin
      read_address = ADDR_W'({row, 6'b0}) - ADDR_W'({row, 2'b0}) + ADDR_W'(col);
    end else begin
      read_address = '0;
    end
  end

endmodule

// File: rtl/door_controller.sv
// Level-exit door controller. Drives the door sprite RAM address, aligns the
// visibility flag with the RAM's one-cycle read latency, animates the door
// lifting open once the key is held, and signals level completion once both
// players have stood at the open door for ENTER_FRAMES consecutive frames.
//
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   frame_clk         once-per-frame level signal (rising edge = frame tick)
//   drawx, drawy      current scan position
//   zerox             camera scroll
//   ram_data          palette index read back from the door frame RAM
//   key_collected     level key obtained
//   p1_at_door        player 1 overlaps the door
//   p2_at_door        player 2 overlaps the door
//   read_address      door frame RAM read address (combinational)
//   door_pixel_on     opaque, visible door pixel aligned with ram_data
//   door_color        palette index when door_pixel_on, else 0
//   door_open         door fully open (OPEN or DONE)
//   level_complete    both players have entered
module door_controller
  import door_pkg::*;
#(
  parameter int DOOR_X       = 2416,
  parameter int DOOR_Y       = 96,
  parameter int DOOR_W       = DOOR_W_C,
  parameter int DOOR_H       = DOOR_H_C,
  parameter int OPEN_STEP    = 4,
  parameter int ENTER_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        drawx,
  input  logic [9:0]        drawy,
  input  logic [11:0]       zerox,
  input  logic [3:0]        ram_data,
  input  logic              key_collected,
  input  logic              p1_at_door,
  input  logic              p2_at_door,
  output logic [ADDR_W-1:0] read_address,
  output logic              door_pixel_on,
  output logic [3:0]        door_color,
  output logic              door_open,
  output logic              level_complete
);

  localparam logic [6:0] ROWS_FULL  = 7'(DOOR_H);
  localparam logic [6:0] ROWS_STEP  = 7'(OPEN_STEP);
  localparam logic [4:0] ENTER_LAST = 5'(ENTER_FRAMES);

  door_state_t state_q, state_n;
  logic [6:0]  open_rows_q, open_rows_n, rows_step;
  logic [4:0]  enter_cnt_q, enter_cnt_n, enter_inc;
  logic        frame_d, tick;
  logic        hit, vis, vis_d;
  logic [6:0]  row;

  door_addr_gen #(
    .SPRITE_X (DOOR_X),
    .SPRITE_Y (DOOR_Y),
    .SPRITE_W (DOOR_W),
    .SPRITE_H (DOOR_H)
  ) u_addr_gen (
    .drawx        (drawx),
    .drawy        (drawy),
    .zerox        (zerox),
    .hit          (hit),
    .row          (row),
    .read_address (read_address)
  );

  // Rows above open_rows have been lifted out of view, so the door appears
  // to rise from the bottom of the sprite upward.
  assign tick = frame_clk & ~frame_d;
  assign vis  = hit & (row >= open_rows_q);

  // The RAM returns data one cycle after the address, so the visibility flag
  // is delayed by one cycle to line up with ram_data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d     <= 1'b0;
      state_q     <= CLOSED;
      open_rows_q <= '0;
      enter_cnt_q <= '0;
      vis_d       <= 1'b0;
    end else begin
      frame_d     <= frame_clk;
      state_q     <= state_n;
      open_rows_q <= open_rows_n;
      enter_cnt_q <= enter_cnt_n;
      vis_d       <= vis;
    end
  end

  // Door FSM. Everything advances only on frame ticks; presence at the door
  // must be continuous across ticks or the entry counter starts over.
  always_comb begin
    state_n        = state_q;
    open_rows_n    = open_rows_q;
    enter_cnt_n    = enter_cnt_q;
    rows_step      = open_rows_q + ROWS_STEP;
    enter_inc      = enter_cnt_q + 5'd1;
    door_open      = 1'b0;
    level_complete = 1'b0;
    case (state_q)
      CLOSED: begin
        if (tick && key_collected) begin
          state_n = OPENING;
        end
      end
      OPENING: begin
        if (tick) begin
          if (rows_step >= ROWS_FULL) begin
            open_rows_n = ROWS_FULL;
            state_n     = OPEN;
          end else begin
            open_rows_n = rows_step;
          end
        end
      end
      OPEN: begin
        door_open = 1'b1;
        if (tick) begin
          if (p1_at_door && p2_at_door) begin
            enter_cnt_n = enter_inc;
            if (enter_inc == ENTER_LAST) begin
              state_n = DONE;
            end
          end else begin
            enter_cnt_n = '0;
          end
        end
      end
      DONE: begin
        door_open      = 1'b1;
        level_complete = 1'b1;
      end
      default: begin
        state_n = CLOSED;
      end
    endcase
  end

  assign door_pixel_on = vis_d & (ram_data != TRANSPARENT_IDX);
  assign door_color    = door_pixel_on ? ram_data : TRANSPARENT_IDX;

endmodule

// File: tb/tb_door_controller.sv
// Directed bench for door_controller: addressing, pixel pipeline, opening
// animation, entry counting, reset behaviour and frame-edge detection.
// Expected values are queued as stimulus is applied and compared by
// check_output when the corresponding DUT output is valid.
module tb_door_controller;

  typedef enum {K_ADDR, K_PIX, K_COLOR, K_OPEN, K_LC} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [12:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_clk;
  logic [9:0]  drawx, drawy;
  logic [11:0] zerox;
  logic [3:0]  ram_data;
  logic        key_collected, p1_at_door, p2_at_door;
  logic [12:0] read_address;
  logic        door_pixel_on;
  logic [3:0]  door_color;
  logic        door_open, level_complete;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  door_controller dut (
    .Clk            (clk),
    .Reset          (reset),
    .frame_clk      (frame_clk),
    .drawx          (drawx),
    .drawy          (drawy),
    .zerox          (zerox),
    .ram_data       (ram_data),
    .key_collected  (key_collected),
    .p1_at_door     (p1_at_door),
    .p2_at_door     (p2_at_door),
    .read_address   (read_address),
    .door_pixel_on  (door_pixel_on),
    .door_color     (door_color),
    .door_open      (door_open),
    .level_complete (level_complete)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expect_out(input string tag, input kind_t kind, input logic [12:0] value);
    exp_t e;
    e.tag   = tag;
    e.kind  = kind;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [12:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_ADDR:  obs = read_address;
        K_PIX:   obs = {12'b0, door_pixel_on};
        K_COLOR: obs = {9'b0, door_color};
        K_OPEN:  obs = {12'b0, door_open};
        default: obs = {12'b0, level_complete};
      endcase
      checks++;
      assert (obs === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] dx, input logic [9:0] dy, input logic [11:0] zx);
    @(negedge clk);
    drawx = dx;
    drawy = dy;
    zerox = zx;
  endtask

  task automatic check_addr(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                            input logic [11:0] zx, input logic [12:0] exp_addr);
    apply_stimulus(dx, dy, zx);
    expect_out(tag, K_ADDR, exp_addr);
    #1 check_output();
  endtask

  // Present a scan position, let the visibility flag register, then return
  // RAM data the following cycle as the real RAM would.
  task automatic probe_pixel(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                             input logic [3:0] data, input logic exp_on);
    apply_stimulus(dx, dy, 12'd2300);
    @(posedge clk);
    #1 ram_data = data;
    expect_out({tag, "_on"}, K_PIX, {12'b0, exp_on});
    expect_out({tag, "_color"}, K_COLOR, exp_on ? {9'b0, data} : 13'd0);
    #1 check_output();
  endtask

  task automatic do_tick();
    @(negedge clk);
    frame_clk = 1'b1;
    @(negedge clk);
    frame_clk = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic exp_open, input logic exp_lc);
    expect_out({tag, "_open"}, K_OPEN, {12'b0, exp_open});
    expect_out({tag, "_lc"}, K_LC, {12'b0, exp_lc});
    #1 check_output();
  endtask

  initial begin
    reset         = 1'b1;
    frame_clk     = 1'b0;
    drawx         = '0;
    drawy         = '0;
    zerox         = '0;
    ram_data      = 4'd5;
    key_collected = 1'b0;
    p1_at_door    = 1'b0;
    p2_at_door    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    expect_out("reset_pix", K_PIX, 13'd0);
    check_flags("reset", 1'b0, 1'b0);

    $display("[TB] addressing");
    check_addr("addr_origin",   10'd116, 10'd96,  12'd2300, 13'd0);
    check_addr("addr_last",     10'd175, 10'd175, 12'd2300, 13'd4799);
    check_addr("addr_right_out", 10'd176, 10'd175, 12'd2300, 13'd0);
    check_addr("addr_mid",      10'd120, 10'd100, 12'd2300, 13'd244);
    check_addr("addr_row1",     10'd116, 10'd97,  12'd2300, 13'd60);
    check_addr("addr_below",    10'd116, 10'd176, 12'd2300, 13'd0);
    check_addr("addr_wrap",     10'd200, 10'd100, 12'd4000, 13'd0);

    $display("[TB] pixel pipeline");
    probe_pixel("pix_opaque", 10'd116, 10'd96, 4'd5, 1'b1);
    probe_pixel("pix_transp", 10'd116, 10'd96, 4'd0, 1'b0);
    probe_pixel("pix_left_out", 10'd115, 10'd96, 4'd5, 1'b0);
    probe_pixel("pix_above_out", 10'd116, 10'd95, 4'd5, 1'b0);

    $display("[TB] opening");
    key_collected = 1'b1;
    repeat (3) @(negedge clk);
    check_flags("key_no_tick", 1'b0, 1'b0);
    probe_pixel("key_no_tick_row0", 10'd116, 10'd96, 4'd7, 1'b1);
    do_tick();
    probe_pixel("opening0_row0", 10'd116, 10'd96, 4'd7, 1'b1);
    do_tick();
    do_tick();
    key_collected = 1'b0;
    probe_pixel("rows8_row7", 10'd120, 10'd103, 4'd7, 1'b0);
    probe_pixel("rows8_row8", 10'd120, 10'd104, 4'd7, 1'b1);

    $display("[TB] edge detect");
    @(negedge clk);
    frame_clk = 1'b1;
    repeat (100) @(negedge clk);
    frame_clk = 1'b0;
    probe_pixel("held_row11", 10'd120, 10'd107, 4'd3, 1'b0);
    probe_pixel("held_row12", 10'd120, 10'd108, 4'd3, 1'b1);

    repeat (16) do_tick();
    check_flags("rows76", 1'b0, 1'b0);
    probe_pixel("rows76_row76", 10'd120, 10'd172, 4'd3, 1'b1);
    do_tick();
    check_flags("rows80", 1'b1, 1'b0);
    probe_pixel("open_row79", 10'd175, 10'd175, 4'd3, 1'b0);

    $display("[TB] entering");
    p1_at_door = 1'b1;
    p2_at_door = 1'b1;
    repeat (29) do_tick();
    check_flags("enter_run1_29", 1'b1, 1'b0);
    p2_at_door = 1'b0;
    do_tick();
    check_flags("enter_drop", 1'b1, 1'b0);
    p2_at_door = 1'b1;
    repeat (29) do_tick();
    check_flags("enter_run2_29", 1'b1, 1'b0);
    do_tick();
    check_flags("enter_run2_30", 1'b1, 1'b1);
    p1_at_door = 1'b0;
    p2_at_door = 1'b0;
    do_tick();
    check_flags("done_sticky", 1'b1, 1'b1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_flags("done_reset", 1'b0, 1'b0);

    $display("[TB] reset mid-animation");
    key_collected = 1'b1;
    do_tick();
    key_collected = 1'b0;
    repeat (10) do_tick();
    probe_pixel("rows40_row39", 10'd120, 10'd135, 4'd6, 1'b0);
    probe_pixel("rows40_row40", 10'd120, 10'd136, 4'd6, 1'b1);
    @(negedge clk);
    reset     = 1'b1;
    frame_clk = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    frame_clk = 1'b0;
    check_flags("mid_reset", 1'b0, 1'b0);
    probe_pixel("mid_reset_row0", 10'd116, 10'd96, 4'd6, 1'b1);
    do_tick();
    probe_pixel("closed_after_tick_row0", 10'd116, 10'd96, 4'd6, 1'b1);
    check_flags("closed_after_tick", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/door_controller.md
Name: door_controller

Overview:
- Upstream companion of the door sprite frame RAM.
- Generates the sprite read address from the scan position and camera scroll, and realigns the hit flag with the RAM's 1-cycle read data.
- Runs the door FSM (closed, opening animation, open, entering, done) and raises level_complete for the level/game-state logic.
- Output door_pixel_on/door_color feeds the colour mapper.

Parameters:
- DOOR_X, 2416: world x of sprite column 0.
- DOOR_Y, 96: screen y of sprite row 0.
- DOOR_W, 60: sprite width in pixels.
- DOOR_H, 80: sprite height in pixels; DOOR_W*DOOR_H = 4800 RAM words.
- OPEN_STEP, 4: rows revealed per frame tick while opening; DOOR_H must be a multiple of OPEN_STEP.
- ENTER_FRAMES, 30: consecutive frame ticks both players must stand at the door.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  once-per-frame level signal, synchronous to Clk
- drawx  in  10  current scan x
- drawy  in  10  current scan y
- zerox  in  12  camera scroll (world x of screen column 0)
- ram_data  in  4  palette index from door frame RAM, valid 1 cycle after read_address
- key_collected  in  1  level key obtained
- p1_at_door  in  1  player 1 overlaps door
- p2_at_door  in  1  player 2 overlaps door
- read_address  out  13  door frame RAM read address (combinational)
- door_pixel_on  out  1  opaque door pixel, aligned with ram_data
- door_color  out  4  palette index when door_pixel_on, else 0
- door_open  out  1  high in OPEN and DONE
- level_complete  out  1  high in DONE

Behaviour:
- Frame tick: frame_d is a registered copy of frame_clk; tick = frame_clk & ~frame_d. frame_d resets to 0.
- World coordinates: nowx = {2'b00,drawx} + zerox, modulo 4096; nowy = {2'b00,drawy}.
- Hit test: hit = (DOOR_X <= nowx <= DOOR_X+DOOR_W-1) and (DOOR_Y <= nowy <= DOOR_Y+DOOR_H-1). Both bounds are inclusive, so the box is exactly 60x80.
- Sprite offsets: col = nowx-DOOR_X (6b), row = nowy-DOOR_Y (7b).
- read_address = row*60 + col when hit, else 0. Build the multiply from shifts and subtracts: (row<<6) - (row<<2) + col. Maximum value is 4799.
- Visibility: vis = hit & (row >= open_rows). Rows above open_rows show background, so the door appears to lift.
- Pipeline: vis_d registered, reset to 0. door_pixel_on = vis_d & (ram_data != 0); index 0 is transparent. Total latency from drawx to door_pixel_on is 1 Clk.
- FSM states: CLOSED, OPENING, OPEN, DONE. Reset gives state CLOSED, open_rows=0, enter_cnt=0, door_open=0, level_complete=0, vis_d=0.
- CLOSED: on tick with key_collected=1, go to OPENING. key_collected without a tick has no effect.
- OPENING: on each tick, open_rows += OPEN_STEP. On the tick where the result equals DOOR_H, go to OPEN. open_rows saturates at DOOR_H. A later drop of key_collected does not re-close the door.
- OPEN: on each tick:
  - if p1_at_door & p2_at_door, enter_cnt += 1; else enter_cnt = 0;
  - the tick that brings enter_cnt to ENTER_FRAMES moves to DONE.
  - Presence is sampled only at ticks.
- DONE: terminal; level_complete=1 and door_open=1 until Reset. Ticks are ignored.
- Reset mid-animation returns the FSM to CLOSED with open_rows=0 on the next edge, and the door redraws fully closed.
- Reset has priority over a tick in the same cycle.
- Scroll wrap: if nowx wraps past 4095 there is no hit and no spurious address.

Decomposition:
- Shared package door_pkg holds:
  - enum door_state_t {CLOSED, OPENING, OPEN, DONE};
  - constants DOOR_W_C=60, DOOR_H_C=80, DOOR_WORDS=4800, TRANSPARENT_IDX=4'h0.
- Sub-module door_addr_gen: combinational hit test and read_address, reusable for other sprite RAMs.
- The FSM and pipeline register stay in door_controller.

Test Plan:
- Addressing: zerox=2300, drawx=116, drawy=96 gives nowx=2416, read_address=0. drawx=175, drawy=175 gives read_address=4799. drawx=176 gives hit=0 and read_address=0.
- Pixel pipeline: in CLOSED, drive an in-box pixel with ram_data=5 one cycle later, so door_pixel_on=1 and door_color=5. With ram_data=0, door_pixel_on=0.
- Opening: key_collected=1 then one tick puts state in OPENING. After 20 further ticks open_rows=80, door_open=1. At open_rows=8, row 7 is hidden and row 8 is visible.
- Entering: in OPEN, both players present for 29 ticks, p2 drops for 1 tick, then both present for 30 ticks. level_complete rises only on the 30th tick of the second run.
- Reset mid-operation: assert Reset at open_rows=40 while a tick fires the same cycle. Then state=CLOSED, open_rows=0, door_open=0, and the row-0 pixel is visible again.
- Edge detect: hold frame_clk high for 100 Clk; open_rows advances exactly one step.
